// File: rtl/gate_check_pkg.sv
// Shared types and constants for the two-input gate truth-table checker.
// Vector k drives {gate_b, gate_a} = k, so the table index doubles as the drive pattern.
package gate_check_pkg;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned VEC_IDX_W   = $clog2(NUM_VECTORS);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StHold,
        StDone
    } state_t;

    typedef logic [NUM_VECTORS-1:0] table_t;
    typedef logic [VEC_IDX_W-1:0]   vec_idx_t;

    // Bitwise disagreement between the captured and the expected truth table.
    function automatic table_t table_diff(input table_t captured, input table_t reference);
        return captured ^ reference;
    endfunction

endpackage

// File: rtl/vector_timer.sv
// Per-vector cycle counter: counts 0..VECTOR_PERIOD-1 while run is high and
// strobes when the settle point and the end of the vector period are reached.
module vector_timer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned VECTOR_PERIOD = 10,
    localparam int unsigned CntW = $clog2(VECTOR_PERIOD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic settle_hit,
    output logic period_end
);

    logic [CntW-1:0] count_q;

    // Strobes are seen in the cycle before the edge at which they take effect.
    assign settle_hit = run && (count_q == CntW'(SETTLE_CYCLES - 1));
    assign period_end = run && (count_q == CntW'(VECTOR_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!run || period_end) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CntW'(1);
        end
    end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps a two-input gate through all four input vectors, captures its output
// into a truth table and compares it with an expected table latched at start.
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned VECTOR_PERIOD = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] expected,
    output logic                   gate_a,
    output logic                   gate_b,
    input  logic                   gate_y,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_VECTORS-1:0] truth_table,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] mismatch
);

    localparam vec_idx_t LastVec = vec_idx_t'(NUM_VECTORS - 1);

    state_t   state_q;
    vec_idx_t vec_q;
    table_t   exp_q;
    logic     run;
    logic     settle_hit;
    logic     period_end;

    assign run = (state_q == StDrive) || (state_q == StHold);

    vector_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .VECTOR_PERIOD(VECTOR_PERIOD)
    ) u_vector_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .settle_hit(settle_hit),
        .period_end(period_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vec_q       <= '0;
            exp_q       <= '0;
            gate_a      <= 1'b0;
            gate_b      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            pass        <= 1'b0;
            mismatch    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StDrive;
                        vec_q       <= '0;
                        exp_q       <= expected;
                        gate_a      <= 1'b0;
                        gate_b      <= 1'b0;
                        busy        <= 1'b1;
                        truth_table <= '0;
                        pass        <= 1'b0;
                        mismatch    <= '0;
                    end
                end
                StDrive: begin
                    if (settle_hit) begin
                        truth_table[vec_q] <= gate_y;
                        state_q            <= StHold;
                    end
                end
                StHold: begin
                    if (period_end) begin
                        if (vec_q == LastVec) begin
                            state_q  <= StDone;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            gate_a   <= 1'b0;
                            gate_b   <= 1'b0;
                            pass     <= (truth_table == exp_q);
                            mismatch <= table_diff(truth_table, exp_q);
                        end else begin
                            // Vector index is the drive pattern: a is bit 0, b is bit 1.
                            vec_q            <= vec_q + vec_idx_t'(1);
                            {gate_b, gate_a} <= vec_q + vec_idx_t'(1);
                            state_q          <= StDrive;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: a behavioural NAND/AND gate on the default
// instance and a two-cycle-delayed NAND on a fast-timing instance, scoreboard-checked.
module tb_gate_truth_checker;

    typedef struct packed {
        logic [3:0] tt;
        logic       pass;
        logic [3:0] mm;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    // Instance 1: default timing
    logic       start1;
    logic [3:0] exp1;
    logic       gate_a1, gate_b1, gate_y1, busy1, done1, pass1;
    logic [3:0] tt1, mm1;
    logic       sel_and;

    // Instance 2: SETTLE_CYCLES=3, VECTOR_PERIOD=5, gate output delayed two cycles
    logic       start2;
    logic [3:0] exp2;
    logic       gate_a2, gate_b2, gate_y2, busy2, done2, pass2;
    logic [3:0] tt2, mm2;
    logic       y2_d1 = 1'b0;
    logic       y2_d2 = 1'b0;

    sb_t        sb1[$];
    sb_t        sb2[$];
    int         done1_cyc[$];
    sb_t        e1, e2;
    int         s0;
    int         lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign gate_y1 = sel_and ? (gate_a1 & gate_b1) : ~(gate_a1 & gate_b1);

    always @(posedge clk) begin
        y2_d1 <= ~(gate_a2 & gate_b2);
        y2_d2 <= y2_d1;
    end
    assign gate_y2 = y2_d2;

    gate_truth_checker u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .expected   (exp1),
        .gate_a     (gate_a1),
        .gate_b     (gate_b1),
        .gate_y     (gate_y1),
        .busy       (busy1),
        .done       (done1),
        .truth_table(tt1),
        .pass       (pass1),
        .mismatch   (mm1)
    );

    gate_truth_checker #(
        .SETTLE_CYCLES(3),
        .VECTOR_PERIOD(5)
    ) u_dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .expected   (exp2),
        .gate_a     (gate_a2),
        .gate_b     (gate_b2),
        .gate_y     (gate_y2),
        .busy       (busy2),
        .done       (done2),
        .truth_table(tt2),
        .pass       (pass2),
        .mismatch   (mm2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic logic [3:0] model_tt(input logic is_and);
        logic [3:0] t;
        logic [1:0] kk;
        for (int k = 0; k < 4; k++) begin
            kk   = 2'(k);
            t[k] = is_and ? (kk[0] & kk[1]) : ~(kk[0] & kk[1]);
        end
        return t;
    endfunction

    function automatic sb_t model_entry(input logic is_and, input logic [3:0] ex);
        sb_t s;
        s.tt   = model_tt(is_and);
        s.pass = (s.tt == ex);
        s.mm   = s.tt ^ ex;
        return s;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding sweep.
    always @(negedge clk) begin
        if (rst_n && done1) begin
            done1_cyc.push_back(cyc);
            if (sb1.size() == 0) begin
                check("dut1_unexpected_done", 32'(done1), 32'd0);
            end else begin
                e1 = sb1.pop_front();
                check("dut1_truth_table", 32'(tt1), 32'(e1.tt));
                check("dut1_pass", 32'(pass1), 32'(e1.pass));
                check("dut1_mismatch", 32'(mm1), 32'(e1.mm));
            end
        end
        if (rst_n && done2) begin
            if (sb2.size() == 0) begin
                check("dut2_unexpected_done", 32'(done2), 32'd0);
            end else begin
                e2 = sb2.pop_front();
                check("dut2_truth_table", 32'(tt2), 32'(e2.tt));
                check("dut2_pass", 32'(pass2), 32'(e2.pass));
                check("dut2_mismatch", 32'(mm2), 32'(e2.mm));
            end
        end
    end

    task automatic pulse_start1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        s0 = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_done1(input int limit, output int l);
        bit seen = 0;
        l = -1;
        for (int i = 0; i < limit && !seen; i++) begin
            if (done1) begin
                seen = 1;
                l = cyc - s0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        exp1    = 4'b0000;
        exp2    = 4'b0000;
        sel_and = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs1", 32'({gate_a1, gate_b1, busy1, done1, tt1, pass1, mm1}), 32'd0);
        check("reset_outs2", 32'({gate_a2, gate_b2, busy2, done2, tt2, pass2, mm2}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // NAND sweep; expected changes mid-sweep and a stray start pulse must be ignored
        exp1 = 4'b0111;
        sb1.push_back(model_entry(1'b0, 4'b0111));
        pulse_start1();
        check("busy_after_start", 32'(busy1), 32'd1);
        wait_until(s0 + 5);
        check("vec0", 32'({gate_b1, gate_a1}), 32'd0);
        wait_until(s0 + 15);
        check("vec1", 32'({gate_b1, gate_a1}), 32'd1);
        exp1 = 4'b0000;
        wait_until(s0 + 20);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_until(s0 + 25);
        check("vec2", 32'({gate_b1, gate_a1}), 32'd2);
        wait_until(s0 + 35);
        check("vec3", 32'({gate_b1, gate_a1}), 32'd3);
        wait_done1(60, lat);
        check("nand_latency", 32'(lat), 32'd40);
        check("done_busy_gates", 32'({busy1, gate_a1, gate_b1}), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done1), 32'd0);
        repeat (5) @(negedge clk);
        check("idle_hold", 32'({tt1, pass1, mm1}), 32'({4'b0111, 1'b1, 4'b0000}));

        // AND gate against NAND expectation
        sel_and = 1'b1;
        exp1    = 4'b0111;
        sb1.push_back(model_entry(1'b1, 4'b0111));
        pulse_start1();
        check("start_clears", 32'({tt1, pass1, mm1}), 32'd0);
        wait_done1(60, lat);
        check("and_latency", 32'(lat), 32'd40);
        repeat (3) @(negedge clk);

        // Reset at cycle 25 of a sweep aborts it without a done pulse
        sel_and = 1'b0;
        sb1.push_back(model_entry(1'b0, 4'b0111));
        pulse_start1();
        wait_until(s0 + 25);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'({gate_a1, gate_b1, busy1, done1, tt1, pass1, mm1}), 32'd0);
        sb1.delete();
        repeat (3) @(negedge clk);
        check("no_done_in_reset", 32'(done1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        sb1.push_back(model_entry(1'b0, 4'b0111));
        pulse_start1();
        wait_done1(60, lat);
        check("post_reset_latency", 32'(lat), 32'd40);
        repeat (3) @(negedge clk);

        // start held high for 100 cycles: sweeps back to back with one idle cycle between
        done1_cyc.delete();
        for (int i = 0; i < 3; i++) sb1.push_back(model_entry(1'b0, 4'b0111));
        start1 = 1'b1;
        @(negedge clk);
        s0 = cyc;
        wait_until(s0 + 99);
        start1 = 1'b0;
        wait_until(s0 + 130);
        check("held_done_count", 32'(done1_cyc.size()), 32'd3);
        if (done1_cyc.size() == 3) begin
            check("held_done0", 32'(done1_cyc[0] - s0), 32'd40);
            check("held_done1", 32'(done1_cyc[1] - s0), 32'd82);
            check("held_done2", 32'(done1_cyc[2] - s0), 32'd124);
        end

        // Short timing with a slow gate
        exp2 = 4'b0111;
        sb2.push_back(model_entry(1'b0, 4'b0111));
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        s0  = cyc;
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (done2) lat = cyc - s0;
            else @(negedge clk);
        end
        check("dut2_latency", 32'(lat), 32'd20);
        repeat (3) @(negedge clk);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        check("sb2_drained", 32'(sb2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
